// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and default bit period.
// Used by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int UART_DATA_BITS    = 8;
    // 50 MHz system clock / 115200 baud
    localparam int UART_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..N-1 and wraps, pulsing tick at N-1.
// clear holds the count at zero so the first bit of a frame is a full period.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per tx_req, sent LSB first as 8N1, or 8E1 when
// built with UART_TX_PARITY_EN and par_en is set at acceptance.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tx_req,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    input  logic                      par_en,
    output logic                      tx,
    output logic                      tx_busy,
    output logic                      tx_end,
    output uart_state_e               dbg_state
);

    localparam int BIT_CNT_W = $clog2(UART_DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(UART_DATA_BITS - 1);

    uart_state_e                 state_q, state_d;
    logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
    logic [BIT_CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                        tx_q, tx_d;
    logic                        baud_clear;
    logic                        baud_tick;

`ifdef UART_TX_PARITY_EN
    logic par_flag_q, par_flag_d;
    logic par_bit_q, par_bit_d;
`else
    logic unused_par_en;
    assign unused_par_en = par_en;
`endif

    // Counter is held at zero while idle so acceptance starts a fresh bit period.
    assign baud_clear = (state_q == ST_IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(baud_clear),
        .tick (baud_tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
        par_flag_d = par_flag_q;
        par_bit_d  = par_bit_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (tx_req) begin
                    state_d   = ST_START;
                    shift_d   = tx_data;
                    bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    par_flag_d = par_en;
                    par_bit_d  = ^tx_data;
`endif
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = par_flag_q ? ST_PARITY : ST_STOP;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_tick) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (baud_tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level follows the state being entered so tx changes on the bit boundary edge.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_bit_q;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_flag_q <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_flag_q <= par_flag_d;
            par_bit_q  <= par_bit_d;
`endif
        end
    end

    assign tx        = tx_q;
    assign tx_busy   = (state_q != ST_IDLE);
    assign tx_end    = (state_q == ST_STOP) && baud_tick;
    assign dbg_state = state_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmit half of the RS232/UART link: accepts one byte per request from the uPC side and shifts it out on `tx` as an asynchronous 8N1 frame, or 8E1 when parity is compiled in and enabled. It complements the receive path, which produces `rx_data`/`rx_ready`, and drives the board's RS232 TX pin through the existing `tx_req`/`tx_end` handshake.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per serial bit (50 MHz / 115200); legal range ≥ 2
- `clk`  in  1  main clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `tx_req`  in  1  request to send; sampled only while idle
- `tx_data`  in  8  byte to send; captured on the accepting edge
- `par_en`  in  1  parity enable; captured with `tx_data`
- `tx`  out  1  serial line, idle high, registered
- `tx_busy`  out  1  high while a frame is in progress (state ≠ IDLE)
- `tx_end`  out  1  one-cycle pulse in the last clock of the stop bit

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `tx`=1. If `tx_req`=1 at an edge, the block latches `tx_data` into the shift register and `par_en` into a flag, then moves to START. The bit counter and the baud counter clear.
- START: `tx`=0 for one bit time, then DATA.
- DATA: 8 bits, LSB first. The shift register shifts right at each bit boundary. After bit 7 the FSM moves to PARITY if the parity flag is set, otherwise to STOP.
- PARITY: `tx` = XOR of the latched byte (even parity) for one bit time, then STOP.
- STOP: `tx`=1 for one bit time. `tx_end`=1 while the baud counter = `CLKS_PER_BIT`-1. The FSM then returns to IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..`CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary.
- `tx_req` asserted while busy is ignored. It is not queued.
- `tx_data` and `par_en` changes after acceptance have no effect on the frame in flight.
- Reset mid-frame aborts the frame. `tx` returns high at the reset edge and no `tx_end` is produced.
- Reset values: state IDLE, `tx`=1, `tx_busy`=0, `tx_end`=0, all counters 0.

## Timing
- Let E0 be the edge that accepts the request and N = `CLKS_PER_BIT`.
- After E0: `tx`=0 and `tx_busy`=1.
- Frame length F = 10 bits, or 11 with parity.
- Bit k occupies the cycles from E0+k·N through E0+(k+1)·N.
- `tx_end` is high for exactly the single cycle following edge E0+F·N−1.
- At edge E0+F·N: state becomes IDLE, `tx_busy`=0, `tx_end`=0.
- The earliest next acceptance is edge E0+F·N+1. Back-to-back frames therefore have 1 clock of idle high between the stop bit and the next start bit.
- Latency from the accepting edge to the `tx_end` rising edge is F·N−1 cycles.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state and parity logic are present, and `par_en` selects 8E1 or 8N1 per frame.
- `UART_TX_PARITY_EN` undefined: the PARITY state and logic are not compiled. `par_en` is still a port but is ignored, and every frame is 8N1 (F = 10).

## Structure
- Shared `uart_pkg` holds:
  - the FSM state encoding (also used by the RX side for consistency);
  - `UART_DATA_BITS`=8;
  - the default `CLKS_PER_BIT`.
- One sub-module, `uart_baud_tick`, holds the parameterised counter. It has a `clear` input and produces a `tick` output at count N−1. Both `uart_tx` and the receiver reuse it.

## Test plan
- All scenarios use N=4.
- Reset: hold `rst` for 3 cycles while `tx_req`=1 → `tx`=1, `tx_busy`=0, `tx_end`=0 throughout, and no frame after reset release unless `tx_req` is still high.
- Send 0xA5 with `par_en`=0 → `tx` sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1. `tx_end` pulses once, 39 cycles after acceptance. `tx_busy` is high for 40 cycles.
- Send 0x03 with `par_en`=1 and the macro defined → after the data bits, parity bit = 0, then stop. `tx_end` follows acceptance by 43 cycles. The same stimulus without the macro gives 10 bits and 39 cycles.
- Pulse `tx_req` with 0x55 mid-frame while sending 0xFF → only 0xFF is transmitted and exactly one `tx_end` occurs.
- Hold `tx_req`=1 continuously with 0x12 then 0x34 → two frames are sent, with exactly 1 idle-high cycle between them.
- Assert `rst` during data bit 3 → at the next edge `tx`=1 and `tx_busy`=0, no `tx_end` occurs, and a new request after release sends a full clean frame.
